// File: rtl/e5rv32_pkg.sv
// Shared constants and types for the e5rv32 core slice: register-file
// geometry, the register-file sequencing states and the writeback select
// encoding.
package e5rv32_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  // Writeback source select encoding (ResultSrcW).
  localparam logic RES_ALU = 1'b0;
  localparam logic RES_MEM = 1'b1;

  // CLEAR zeroes the array after reset; RUN is normal operation.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/wb_select.sv
// Writeback result mux plus read-port data select. The register file
// instantiates one copy per read port.
// Build option: define REGFILE_BYPASS_EN to forward the writeback data
// combinationally to a read port that addresses the register being written.
module wb_select
  import e5rv32_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0]      result_i,
  input  logic [XLEN-1:0]      read_data_i,
  input  logic                 result_src_i,
  input  logic                 reg_write_i,
  input  logic [REG_IDX_W-1:0] rd_i,
  input  logic [REG_IDX_W-1:0] addr_i,
  input  logic [XLEN-1:0]      stored_i,
  input  logic                 run_i,
  output logic [XLEN-1:0]      wd_o,
  output logic [XLEN-1:0]      rd_data_o
);

  logic [XLEN-1:0] wd;
  logic            hit;

  // Writeback data: load data or ALU/PC result.
  assign wd   = (result_src_i == RES_MEM) ? read_data_i : result_i;
  assign wd_o = wd;

`ifdef REGFILE_BYPASS_EN
  assign hit = run_i && reg_write_i && (rd_i != '0) && (rd_i == addr_i);
`else
  // Without the bypass the falling-edge write supplies the forwarding.
  assign hit = 1'b0;
  logic unused_wb;
  assign unused_wb = ^{reg_write_i, rd_i};
`endif

  // Read data: zero while clearing or for x0, else bypass or stored value.
  // NOTE: every output of a combinational block is given a default first so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_data_o = '0;
    if (run_i && (addr_i != '0)) begin
      rd_data_o = hit ? wd : stored_i;
    end
  end

endmodule

// File: rtl/regfile_wb.sv
// Integer register file with writeback stage. After reset an internal
// sequencer zeroes x1..x31 one per falling edge while ClearBusy stalls the
// core. All state changes on the falling clock edge, which gives the
// decode stage half-cycle forwarding of writebacks.
// Build option: REGFILE_BYPASS_EN adds a combinational write-to-read bypass
// (see wb_select).
module regfile_wb
  import e5rv32_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XLEN-1:0]      ResultW,
  input  logic [XLEN-1:0]      ReadDataW,
  input  logic                 ResultSrcW,
  input  logic                 RegWriteW,
  input  logic [REG_IDX_W-1:0] RdW,
  input  logic [REG_IDX_W-1:0] A1D,
  input  logic [REG_IDX_W-1:0] A2D,
  output logic [XLEN-1:0]      RD1D,
  output logic [XLEN-1:0]      RD2D,
  output logic                 ClearBusy
);

  rf_state_t            state_q, state_d;
  logic [REG_IDX_W-1:0] cnt_q, cnt_d;
  logic                 clr_we, run_we;
  logic                 run;
  logic [XLEN-1:0]      wd, wd_unused;

  // Entry 0 exists only to keep indexing simple; it is never written and
  // every read of index 0 is masked to zero.
  logic [XLEN-1:0]      regs_q [NUM_REGS];

  assign run       = (state_q == RUN);
  assign ClearBusy = (state_q == CLEAR);

  // State and clear counter; reset restarts clearing from x1.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CLEAR;
      cnt_q   <= REG_IDX_W'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter advance and write enables.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    run_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + REG_IDX_W'(1);
        if (cnt_q == REG_IDX_W'(NUM_REGS - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        run_we = RegWriteW && (RdW != '0);
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Register array: clear sweep or writeback. Reset forces CLEAR
  // asynchronously, so no writeback lands on an edge while reset is low.
  // NOTE: the array has no reset; it is zeroed by the clear sweep instead,
  // which keeps it mappable onto plain storage.
  always_ff @(negedge clk) begin
    if (clr_we) begin
      regs_q[cnt_q] <= '0;
    end else if (run_we) begin
      regs_q[RdW] <= wd;
    end
  end

  wb_select #(.XLEN(XLEN)) u_sel1 (
    .result_i     (ResultW),
    .read_data_i  (ReadDataW),
    .result_src_i (ResultSrcW),
    .reg_write_i  (RegWriteW),
    .rd_i         (RdW),
    .addr_i       (A1D),
    .stored_i     (regs_q[A1D]),
    .run_i        (run),
    .wd_o         (wd),
    .rd_data_o    (RD1D)
  );

  wb_select #(.XLEN(XLEN)) u_sel2 (
    .result_i     (ResultW),
    .read_data_i  (ReadDataW),
    .result_src_i (ResultSrcW),
    .reg_write_i  (RegWriteW),
    .rd_i         (RdW),
    .addr_i       (A2D),
    .stored_i     (regs_q[A2D]),
    .run_i        (run),
    .wd_o         (wd_unused),
    .rd_data_o    (RD2D)
  );

endmodule

// File: doc/regfile_wb.md
REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width of each register and port.
REQ-002 SHALL have port clk  input  1  core clock; all state changes on the falling edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ResultW  input  XLEN  ALU/PC result from the MEM/WB register.
REQ-005 SHALL have port ReadDataW  input  XLEN  load data from the MEM/WB register.
REQ-006 SHALL have port ResultSrcW  input  1  writeback select: 0 = ResultW, 1 = ReadDataW.
REQ-007 SHALL have port RegWriteW  input  1  writeback enable.
REQ-008 SHALL have port RdW  input  5  destination register index.
REQ-009 SHALL have ports A1D, A2D  input  5 each  decode-stage source register indices.
REQ-010 SHALL have ports RD1D, RD2D  output  XLEN each  decode-stage read data.
REQ-011 SHALL have port ClearBusy  output  1  high while the post-reset clear sequence runs; the core stalls on it.

Function
REQ-012 SHALL hold 31 writable registers x1..x31; x0 SHALL read as 0 always and never be written.
REQ-013 SHALL form write data WD as ReadDataW when ResultSrcW=1, else ResultW.
REQ-014 SHALL write WD to x[RdW] on the falling clk edge when state is RUN, RegWriteW=1 and RdW!=0.
REQ-015 SHALL provide combinational reads: RDnD = x[AnD], or 0 when AnD=0.
REQ-016 SHALL force RD1D and RD2D to 0 while ClearBusy=1.
REQ-017 SHALL implement the FSM states CLEAR and RUN, with a 5-bit clear counter.
REQ-018 In CLEAR, on each falling edge, SHALL write 0 to x[cnt] and increment cnt.
REQ-019 In CLEAR, writeback requests SHALL be ignored.
REQ-020 SHALL transition CLEAR->RUN on the falling edge that clears x31, so that cnt wraps 31->0.
REQ-021 SHALL keep RUN as a terminal state; only reset re-enters CLEAR.
REQ-022 ClearBusy SHALL equal (state==CLEAR), which is high for exactly 31 falling edges after reset deassertion.
REQ-023 Simultaneous write and read of the same index in RUN: see REQ-031/032.
REQ-024 A write to x0 in RUN SHALL have no effect, and read of x0 SHALL remain 0.

Reset
REQ-025 Assertion of reset SHALL immediately force state=CLEAR and cnt=1.
REQ-026 While reset is asserted, ClearBusy SHALL be 1 and RD1D=RD2D=0.
REQ-027 Register array contents SHALL not be reset directly; they are zeroed only by the clear sequence.
REQ-028 Reset asserted mid-clear SHALL restart the sequence from x1.
REQ-029 Reset asserted in RUN SHALL abandon any write on that edge.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN SHALL select the write-to-read bypass.
REQ-031 With REGFILE_BYPASS_EN defined, in RUN, RDnD SHALL return WD combinationally when RegWriteW=1, RdW!=0 and RdW==AnD.
REQ-032 With REGFILE_BYPASS_EN undefined, RDnD SHALL return the stored value only, and the falling-edge write provides the half-cycle forwarding.

Structure
REQ-033 Shared package e5rv32_pkg SHALL hold XLEN_DEF=32, REG_IDX_W=5, NUM_REGS=32 and the enum rf_state_t {CLEAR, RUN}.
REQ-034 The package SHALL also hold the ResultSrcW encoding constants RES_ALU=0 and RES_MEM=1.
REQ-035 The result mux and bypass compare SHALL be one sub-module, wb_select, instantiated once per read port; the array and FSM stay in regfile_wb.

Verification
REQ-036 Scenario: reset low then high -> ClearBusy=1 for 31 falling edges, then 0; afterwards all A1D=1..31 read 0.
REQ-037 Scenario: RUN, RegWriteW=1, RdW=5, ResultSrcW=0, ResultW=0xDEADBEEF -> after the falling edge, A1D=5 gives RD1D=0xDEADBEEF.
REQ-038 Scenario: RdW=0, WD=0x12345678 -> A2D=0 gives RD2D=0.
REQ-039 Scenario: ResultSrcW=1, ReadDataW=0xCAFEF00D, RdW=7, A1D=A2D=7 in the same cycle -> with the macro, both outputs read 0xCAFEF00D before the edge; without it, they read the old value before the edge and the new value after it.
REQ-040 Scenario: reset pulse after 10 clear edges -> ClearBusy stays 1 and 31 further edges are required; a write requested during clear (RdW=3, 0xFF) leaves x3=0.
REQ-041 Scenario: reset asserted in RUN during a write to x9 -> x9 is unchanged, then the clear sequence zeroes it.
